f_accum: RTL and testbench



---
 rtl/f_accum.sv | 254 +++++++++++++++++++++++++
 tb/tb_f_accum.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/f_accum.sv
// f_accum: streaming FP32 accumulator with ADD_LAT interleaved partial sums and a serial final reduction.
// Optional build macro F_ACCUM_RELU_EN clamps negative-signed results to +0.0 when out0 is loaded.
module f_accum #(
    parameter int DATA_W  = 32,
    parameter int ADD_LAT = 4,
    parameter int LEN_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              running,
    input  logic              run,
    input  logic [DATA_W-1:0] in0,
    input  logic [LEN_W-1:0]  len,
    input  logic [7:0]        delay0,
    output logic [DATA_W-1:0] out0,
    output logic              done,
    output logic [2:0]        dbg_state
);

    // Protocol: a one-cycle run pulse (re)starts a job from any state; done stays high with
    // out0 valid until the next run, running low, or rst. There is no backpressure on in0.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        ACCUM  = 3'd2,
        DRAIN  = 3'd3,
        REDUCE = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t            state;
    logic [7:0]        cnt;
    logic [3:0]        k;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  len_q;
    logic [2:0]        slot;
    logic [DATA_W-1:0] out_q;
    logic              done_q;

    logic [DATA_W-1:0] p [8];
    logic [DATA_W-1:0] pipe_sum  [ADD_LAT];
    logic              pipe_vld  [ADD_LAT];
    logic [2:0]        pipe_slot [ADD_LAT];

    logic [DATA_W-1:0] add_a, add_b, s_out;
    logic              v_out, acc_issue;
    logic [2:0]        slot_out;

    // IEEE-754 binary32 addition, round-to-nearest-even, subnormals supported.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, res;
        logic [7:0]  ex, ey, d;
        logic [23:0] mx, my;
        logic [26:0] sml, lost;
        logic [27:0] sum;
        logic [9:0]  e, sh;
        logic [4:0]  lz;
        logic [24:0] rm;
        logic        a_nan, b_nan, a_inf, b_inf, rup;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex   = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey   = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx   = {x[30:23] != 8'd0, x[22:0]};
        my   = {y[30:23] != 8'd0, y[22:0]};
        d    = ex - ey;
        lost = (27'd1 << d) - 27'd1;
        if (d >= 8'd27)
            sml = {26'd0, my != 24'd0};
        else
            sml = ({my, 3'b000} >> d) | {26'd0, ({my, 3'b000} & lost) != 27'd0};
        e = {2'b00, ex};
        if (x[31] == y[31]) begin
            sum = {1'b0, mx, 3'b000} + {1'b0, sml};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e   = e + 10'd1;
            end
        end else begin
            sum = {1'b0, mx, 3'b000} - {1'b0, sml};
            lz  = 5'd27;
            for (int i = 0; i < 27; i++)
                if (sum[i]) lz = 5'(26 - i);
            // Normalise left, but never below the subnormal exponent.
            sh  = ({5'd0, lz} > e - 10'd1) ? e - 10'd1 : {5'd0, lz};
            sum = sum << sh;
            e   = e - sh;
        end
        rup = sum[2] & (sum[1] | sum[0] | sum[3]);
        rm  = {1'b0, sum[26:3]} + {24'd0, rup};
        if (rm[24]) begin
            rm = {1'b0, rm[24:1]};
            e  = e + 10'd1;
        end
        if (e >= 10'd255)
            res = {x[31], 8'hFF, 23'd0};
        else if (rm == 25'd0)
            res = {x[31] & y[31], 31'd0};
        else
            res = {x[31], rm[23] ? e[7:0] : 8'd0, rm[22:0]};
        if (a_nan)
            res = a | 32'h0040_0000;
        else if (b_nan)
            res = b | 32'h0040_0000;
        else if (a_inf && b_inf)
            res = (a[31] != b[31]) ? 32'h7FC0_0000 : a;
        else if (a_inf)
            res = a;
        else if (b_inf)
            res = b;
        return res;
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef F_ACCUM_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    assign s_out     = pipe_sum[ADD_LAT-1];
    assign v_out     = pipe_vld[ADD_LAT-1];
    assign slot_out  = pipe_slot[ADD_LAT-1];
    assign acc_issue = running && !run && (state == ACCUM) && (len_q != '0);

    // In ACCUM the adder output is exactly the partial of the slot being issued, so it is
    // fed straight back; the first lap of each slot sees no valid result and adds to +0.0.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (state == ACCUM) begin
            add_a = in0;
            add_b = v_out ? s_out : '0;
        end else if (state == REDUCE) begin
            add_a = (k == 4'd1) ? p[0] : s_out;
            add_b = p[k[2:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ADD_LAT; i++) begin
                pipe_sum[i]  <= '0;
                pipe_vld[i]  <= 1'b0;
                pipe_slot[i] <= '0;
            end
        end else begin
            pipe_sum[0]  <= fp_add(add_a, add_b);
            pipe_vld[0]  <= acc_issue;
            pipe_slot[0] <= slot;
            for (int i = 1; i < ADD_LAT; i++) begin
                pipe_sum[i]  <= pipe_sum[i-1];
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_slot[i] <= pipe_slot[i-1];
            end
            if (!running || run)
                for (int i = 1; i < ADD_LAT; i++) pipe_vld[i] <= 1'b0;
        end
    end

    // Latest returned sum per slot; after DRAIN these are the final partials.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) p[i] <= '0;
        end else if (!running || run) begin
            for (int i = 0; i < 8; i++) p[i] <= '0;
        end else if (v_out) begin
            p[slot_out] <= s_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            k      <= '0;
            idx    <= '0;
            len_q  <= '0;
            slot   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else if (!running) begin
            state  <= IDLE;
            out_q  <= '0;
            done_q <= 1'b0;
        end else if (run) begin
            state  <= (delay0 == 8'd0) ? ACCUM : DELAY;
            cnt    <= delay0;
            k      <= 4'd1;
            idx    <= '0;
            len_q  <= len;
            slot   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                DELAY: begin
                    if (cnt == 8'd1) state <= ACCUM;
                    else cnt <= cnt - 8'd1;
                end
                ACCUM: begin
                    if (len_q == '0) begin
                        state  <= DONE;
                        out_q  <= '0;
                        done_q <= 1'b1;
                    end else begin
                        idx  <= idx + LEN_W'(1);
                        slot <= (slot == 3'(ADD_LAT - 1)) ? 3'd0 : slot + 3'd1;
                        if (idx == len_q - LEN_W'(1)) begin
                            state <= DRAIN;
                            cnt   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == 8'(ADD_LAT - 1)) begin
                        state <= REDUCE;
                        cnt   <= '0;
                        k     <= 4'd1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                REDUCE: begin
                    // One chained addition every ADD_LAT cycles; k is the next partial to fold in.
                    if (cnt == 8'd0 && k == 4'(ADD_LAT)) begin
                        state  <= DONE;
                        out_q  <= relu(s_out);
                        done_q <= 1'b1;
                    end else begin
                        cnt <= (cnt == 8'(ADD_LAT - 1)) ? 8'd0 : cnt + 8'd1;
                        if (cnt == 8'd0) k <= k + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out0      = running ? out_q : '0;
    assign done      = running & done_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_f_accum.sv
// Directed bench for f_accum: vector table of whole jobs plus hand sequences for abort, rst and running.
module tb_f_accum;

    localparam logic [31:0] ONE   = 32'h3F80_0000;
    localparam logic [31:0] THREE = 32'h4040_0000;
    localparam logic [31:0] JUNK  = 32'h7F80_0000;
    localparam logic [2:0]  ST_IDLE = 3'd0;
    localparam int          NV = 11;

    logic        clk, rst, running, run, done;
    logic [31:0] in0, out0;
    logic [15:0] len;
    logic [7:0]  delay0;
    logic [2:0]  dbg_state;

    typedef struct {
        logic [7:0]  d0;
        logic [15:0] len;
        logic [31:0] data;
        logic [31:0] exp_out;
        int          exp_cyc;
    } vec_t;

    vec_t        vecs [NV];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc;

    f_accum dut (
        .clk       (clk),
        .rst       (rst),
        .running   (running),
        .run       (run),
        .in0       (in0),
        .len       (len),
        .delay0    (delay0),
        .out0      (out0),
        .done      (done),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic start_run(input logic [7:0] d, input logic [15:0] l);
        @(negedge clk);
        run    = 1'b1;
        delay0 = d;
        len    = l;
        in0    = JUNK;
        @(posedge clk);
    endtask

    // Drives in0 relative to the last run edge and returns the cycle done first seen high.
    task automatic wait_done(input int t0, input int l, input logic [31:0] data,
                             input int limit, output int dcyc);
        dcyc = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            run = 1'b0;
            if (done === 1'b1) begin
                dcyc = c - 1;
                break;
            end
            in0 = (c >= t0 && c < t0 + l) ? data : JUNK;
            @(posedge clk);
        end
    endtask

    task automatic feed(input int n, input logic [31:0] data);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            run = 1'b0;
            in0 = data;
            @(posedge clk);
        end
    endtask

    task automatic hold_check(input string name, input logic [31:0] exp_v);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({name, "_hold_done"}, {31'd0, done}, 32'd1);
        check({name, "_hold_out0"}, out0, exp_v);
    endtask

    initial begin
        vecs[0]  = '{8'd0,   16'd8, 32'h3F80_0000, 32'h4100_0000, 25};
        vecs[1]  = '{8'd4,   16'd3, 32'h4000_0000, 32'h40C0_0000, 24};
        vecs[2]  = '{8'd0,   16'd0, 32'h3F80_0000, 32'h0000_0000, 1};
        vecs[3]  = '{8'd0,   16'd2, 32'h3F00_0000, 32'h3F80_0000, 19};
`ifdef F_ACCUM_RELU_EN
        vecs[4]  = '{8'd0,   16'd2, 32'hC040_0000, 32'h0000_0000, 19};
`else
        vecs[4]  = '{8'd0,   16'd2, 32'hC040_0000, 32'hC0C0_0000, 19};
`endif
        vecs[5]  = '{8'd1,   16'd5, 32'h3FC0_0000, 32'h40F0_0000, 23};
        vecs[6]  = '{8'd0,   16'd2, 32'h8000_0000, 32'h0000_0000, 19};
        vecs[7]  = '{8'd0,   16'd5, 32'h3F80_0001, 32'h40A0_0001, 22};
        vecs[8]  = '{8'd0,   16'd2, 32'h7F7F_FFFF, 32'h7F80_0000, 19};
        vecs[9]  = '{8'd255, 16'd1, 32'h3F80_0000, 32'h3F80_0000, 273};
        vecs[10] = '{8'd0,   16'd9, 32'h3F80_0000, 32'h4110_0000, 26};

        rst = 1'b1; running = 1'b1; run = 1'b0; in0 = '0; len = '0; delay0 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out0", out0, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            exp_q.push_back(vecs[v].exp_out);
            start_run(vecs[v].d0, vecs[v].len);
            wait_done(int'(vecs[v].d0) + 1, int'(vecs[v].len), vecs[v].data,
                      vecs[v].exp_cyc + 20, cyc);
            check($sformatf("vec%0d_done_cycle", v), 32'(cyc), 32'(vecs[v].exp_cyc));
            check($sformatf("vec%0d_out0", v), out0, exp_q.pop_front());
            hold_check($sformatf("vec%0d", v), vecs[v].exp_out);
        end

        // Restart mid-job: only the second job's result and timing may appear.
        exp_q.push_back(32'h40C0_0000);
        start_run(8'd0, 16'd10);
        feed(4, ONE);
        start_run(8'd0, 16'd2);
        wait_done(1, 2, THREE, 40, cyc);
        check("abort_done_cycle", 32'(cyc), 32'd19);
        check("abort_out0", out0, exp_q.pop_front());
        hold_check("abort", 32'h40C0_0000);

        // Asynchronous reset while holding a result, then mid-accumulation.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_hold_out0", out0, 32'd0);
        check("rst_hold_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_run(8'd0, 16'd8);
        feed(6, ONE);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("rst_mid_out0", out0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(32'h4100_0000);
        start_run(8'd0, 16'd8);
        wait_done(1, 8, ONE, 45, cyc);
        check("post_rst_done_cycle", 32'(cyc), 32'd25);
        check("post_rst_out0", out0, exp_q.pop_front());

        // running low: outputs clear at once, FSM idles after one edge.
        @(negedge clk);
        running = 1'b0;
        #1;
        check("running_low_out0", out0, 32'd0);
        check("running_low_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("running_low_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        running = 1'b1;
        @(negedge clk);
        check("running_back_done", {31'd0, done}, 32'd0);
        start_run(8'd0, 16'd8);
        feed(3, ONE);
        @(negedge clk);
        running = 1'b0;
        @(negedge clk);
        check("running_mid_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        running = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("running_mid_no_done", {31'd0, done}, 32'd0);
        exp_q.push_back(32'h4100_0000);
        start_run(8'd0, 16'd8);
        wait_done(1, 8, ONE, 45, cyc);
        check("post_running_done_cycle", 32'(cyc), 32'd25);
        check("post_running_out0", out0, exp_q.pop_front());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
